mouse_event_ctrl: RTL and testbench
===================================

Name: mouse_event_ctrl

Overview:
- Sits after cursor_sync in the pclk domain.
- Debounces the synchronised mouse buttons and clamps the cursor position to the visible screen.
- Classifies button activity into click, drag-start and drag-end events.
- Delivers one event at a time to game logic over a valid/ready handshake; dropped events are flagged.

Parameters:
DEBOUNCE_CYC, 4, consecutive cycles a raw button level must differ from the debounced level before the debounced level flips (1..255)
DRAG_THRESH, 4, pixel displacement from press origin that turns a press into a drag (strictly greater than)
XMAX, 799, maximum legal x coordinate
YMAX, 599, maximum legal y coordinate

Ports:
pclk  input  1  pixel clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
xpos  input  12  synchronised cursor x
ypos  input  12  synchronised cursor y
left  input  1  synchronised raw left button
right  input  1  synchronised raw right button
xpos_clamp  output  12  registered x, clamped to XMAX
ypos_clamp  output  12  registered y, clamped to YMAX
dragging  output  1  high while FSM is in DRAG
evt_valid  output  1  event slot holds an event
evt_ready  input  1  consumer accepts event
evt_type  output  2  0=CLICK_L, 1=CLICK_R, 2=DRAG_START, 3=DRAG_END
evt_x  output  12  event position
evt_y  output  12  event position
evt_x0  output  12  drag origin x (equals evt_x for clicks)
evt_y0  output  12  drag origin y (equals evt_y for clicks)
evt_overflow  output  1  sticky: an event was dropped
clr_overflow  input  1  clears evt_overflow

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - FSM to IDLE; debounced buttons 0; debounce counters, origin registers and event slot cleared.
  - Reset mid-press or mid-drag abandons it; no event is emitted.
- Clamp:
  - xpos_clamp = min(xpos, XMAX) and ypos_clamp = min(ypos, YMAX), registered, 1-cycle latency.
  - All FSM and event positions use the clamped values.
- Debounce, per button independently:
  - Counter resets to 0 whenever raw == debounced.
  - Counter increments while raw != debounced.
  - When the counter reaches DEBOUNCE_CYC-1 and raw still differs, the debounced level flips at that edge and the counter resets.
  - A raw change held from edge t is therefore visible at edge t+DEBOUNCE_CYC. Any shorter glitch is ignored.
- Left-button FSM:
  - IDLE: on debounced left rise, latch x0,y0 = current clamped position; go to PRESSED.
  - PRESSED, debounced left fall: emit CLICK_L at (x0,y0); go to IDLE. Fall takes priority over threshold in the same cycle.
  - PRESSED, otherwise: if |x-x0| > DRAG_THRESH or |y-y0| > DRAG_THRESH (13-bit signed difference), emit DRAG_START with evt_x/evt_y = x0/y0; go to DRAG.
  - DRAG: dragging=1. On debounced left fall, emit DRAG_END with evt_x/evt_y = current position and evt_x0/evt_y0 = origin; go to IDLE.
- Right button:
  - Debounced rise emits CLICK_R at the current position, independent of FSM state.
- Event slot (single entry):
  - A generated event loads at the next edge if the slot is empty, or if evt_valid && evt_ready in that cycle (back-to-back throughput of 1 event/cycle).
  - If the slot is occupied and not draining, the new event is dropped and evt_overflow is set.
  - If left and right events occur in the same cycle, the left event is taken, the right event is dropped and evt_overflow is set.
  - While evt_valid=1 and evt_ready=0, all payload outputs are held stable.
  - evt_valid deasserts the edge after acceptance unless a new event loads.
- Overflow:
  - evt_overflow clears on clr_overflow=1.
  - A simultaneous set and clear results in set.
- Latency: from debounced edge to evt_valid is 1 cycle.

Test Plan:
1. DEBOUNCE_CYC=4: left pulse of 3 cycles, then left held 4 cycles at pos (100,50), released after 10 cycles, evt_ready=1 -> no event for the pulse; CLICK_L with evt_x=100, evt_y=50 one cycle after the debounced fall.
2. Press at (200,200), move to (205,200), release -> DRAG_START with x0=200 and dragging=1 one cycle later; at release, DRAG_END with evt_x=205, evt_x0=200.
3. Press at (200,200), move to (204,200) (exactly DRAG_THRESH), release -> CLICK_L only, dragging never asserts.
4. xpos=1500, ypos=4095 -> xpos_clamp=799, ypos_clamp=599 after 1 cycle.
5. evt_ready=0, then generate CLICK_R followed by CLICK_L -> slot holds CLICK_R unchanged, evt_overflow=1; clr_overflow pulse -> evt_overflow=0.
6. Assert rst while in DRAG -> dragging=0 and evt_valid=0 immediately (asynchronous); after release of rst no DRAG_END is emitted.

Source files
------------

// File: rtl/mouse_event_ctrl.sv
// Mouse front end in the pclk domain: position clamp, button debounce,
// click/drag classification and a single-entry valid/ready event slot.
module mouse_event_ctrl #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int DRAG_THRESH  = 4,
   parameter int XMAX         = 799,
   parameter int YMAX         = 599
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic        left,
   input  logic        right,
   output logic [11:0] xpos_clamp,
   output logic [11:0] ypos_clamp,
   output logic        dragging,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [1:0]  evt_type,
   output logic [11:0] evt_x,
   output logic [11:0] evt_y,
   output logic [11:0] evt_x0,
   output logic [11:0] evt_y0,
   output logic        evt_overflow,
   input  logic        clr_overflow
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRESSED = 2'd1, S_DRAG = 2'd2} state_t;

   localparam logic [1:0] EVT_CLICK_L    = 2'd0;
   localparam logic [1:0] EVT_CLICK_R    = 2'd1;
   localparam logic [1:0] EVT_DRAG_START = 2'd2;
   localparam logic [1:0] EVT_DRAG_END   = 2'd3;

   // Returns {next debounced level, next counter}.
   function automatic logic [8:0] deb_next(input logic raw, input logic db, input logic [7:0] cnt);
      if (raw == db) begin
         return {db, 8'd0};
      end else if (cnt == 8'(DEBOUNCE_CYC - 1)) begin
         return {raw, 8'd0};
      end else begin
         return {db, cnt + 8'd1};
      end
   endfunction

   function automatic logic [12:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
      logic signed [12:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d[12]) begin
         return $unsigned(-d);
      end else begin
         return $unsigned(d);
      end
   endfunction

   state_t      state_q, state_d;
   logic [11:0] xc_q, xc_d, yc_q, yc_d;
   logic [11:0] x0_q, x0_d, y0_q, y0_d;
   logic        dbl_q, dbl_d, dbr_q, dbr_d, dbl_prev_q, dbr_prev_q;
   logic [7:0]  cntl_q, cntl_d, cntr_q, cntr_d;
   logic        drag_q, drag_d, vld_q, vld_d, ovf_q, ovf_d;
   logic [1:0]  typ_q, typ_d;
   logic [11:0] ex_q, ex_d, ey_q, ey_d, ex0_q, ex0_d, ey0_q, ey0_d;

   logic        rise_l_s, fall_l_s, rise_r_s, thresh_s, can_load_s, set_ovf_s;
   logic        l_evt_s;
   logic [1:0]  l_typ_s;
   logic [11:0] l_x_s, l_y_s, l_x0_s, l_y0_s;

   // Next-state logic: clamp, debounce, left-button FSM and event slot.
   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      vld_d   = vld_q;
      typ_d   = typ_q;
      ex_d    = ex_q;
      ey_d    = ey_q;
      ex0_d   = ex0_q;
      ey0_d   = ey0_q;
      l_evt_s = 1'b0;
      l_typ_s = EVT_CLICK_L;
      l_x_s   = x0_q;
      l_y_s   = y0_q;
      l_x0_s  = x0_q;
      l_y0_s  = y0_q;
      set_ovf_s = 1'b0;

      xc_d = (xpos > 12'(XMAX)) ? 12'(XMAX) : xpos;
      yc_d = (ypos > 12'(YMAX)) ? 12'(YMAX) : ypos;

      {dbl_d, cntl_d} = deb_next(left, dbl_q, cntl_q);
      {dbr_d, cntr_d} = deb_next(right, dbr_q, cntr_q);

      rise_l_s = dbl_q & ~dbl_prev_q;
      fall_l_s = ~dbl_q & dbl_prev_q;
      rise_r_s = dbr_q & ~dbr_prev_q;
      thresh_s = (abs_diff(xc_q, x0_q) > 13'(DRAG_THRESH)) ||
                 (abs_diff(yc_q, y0_q) > 13'(DRAG_THRESH));

      case (state_q)
         S_IDLE: begin
            if (rise_l_s) begin
               x0_d    = xc_q;
               y0_d    = yc_q;
               state_d = S_PRESSED;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PRESSED: begin
            // A release wins over crossing the drag threshold in the same cycle.
            if (fall_l_s) begin
               l_evt_s = 1'b1;
               l_typ_s = EVT_CLICK_L;
               state_d = S_IDLE;
            end else if (thresh_s) begin
               l_evt_s = 1'b1;
               l_typ_s = EVT_DRAG_START;
               state_d = S_DRAG;
            end else begin
               state_d = S_PRESSED;
            end
         end
         S_DRAG: begin
            if (fall_l_s) begin
               l_evt_s = 1'b1;
               l_typ_s = EVT_DRAG_END;
               l_x_s   = xc_q;
               l_y_s   = yc_q;
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAG;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      drag_d = (state_d == S_DRAG);

      can_load_s = ~vld_q | evt_ready;
      if (vld_q && evt_ready) begin
         vld_d = 1'b0;
      end else begin
         vld_d = vld_q;
      end

      if (l_evt_s) begin
         if (can_load_s) begin
            vld_d = 1'b1;
            typ_d = l_typ_s;
            ex_d  = l_x_s;
            ey_d  = l_y_s;
            ex0_d = l_x0_s;
            ey0_d = l_y0_s;
         end else begin
            set_ovf_s = 1'b1;
         end
         if (rise_r_s) begin
            set_ovf_s = 1'b1;
         end else begin
            set_ovf_s = set_ovf_s;
         end
      end else if (rise_r_s) begin
         if (can_load_s) begin
            vld_d = 1'b1;
            typ_d = EVT_CLICK_R;
            ex_d  = xc_q;
            ey_d  = yc_q;
            ex0_d = xc_q;
            ey0_d = yc_q;
         end else begin
            set_ovf_s = 1'b1;
         end
      end else begin
         set_ovf_s = 1'b0;
      end

      if (set_ovf_s) begin
         ovf_d = 1'b1;
      end else if (clr_overflow) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         xc_q       <= 12'd0;
         yc_q       <= 12'd0;
         x0_q       <= 12'd0;
         y0_q       <= 12'd0;
         dbl_q      <= 1'b0;
         dbr_q      <= 1'b0;
         dbl_prev_q <= 1'b0;
         dbr_prev_q <= 1'b0;
         cntl_q     <= 8'd0;
         cntr_q     <= 8'd0;
         drag_q     <= 1'b0;
         vld_q      <= 1'b0;
         ovf_q      <= 1'b0;
         typ_q      <= 2'd0;
         ex_q       <= 12'd0;
         ey_q       <= 12'd0;
         ex0_q      <= 12'd0;
         ey0_q      <= 12'd0;
      end else begin
         state_q    <= state_d;
         xc_q       <= xc_d;
         yc_q       <= yc_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         dbl_q      <= dbl_d;
         dbr_q      <= dbr_d;
         dbl_prev_q <= dbl_q;
         dbr_prev_q <= dbr_q;
         cntl_q     <= cntl_d;
         cntr_q     <= cntr_d;
         drag_q     <= drag_d;
         vld_q      <= vld_d;
         ovf_q      <= ovf_d;
         typ_q      <= typ_d;
         ex_q       <= ex_d;
         ey_q       <= ey_d;
         ex0_q      <= ex0_d;
         ey0_q      <= ey0_d;
      end
   end

   assign xpos_clamp   = xc_q;
   assign ypos_clamp   = yc_q;
   assign dragging     = drag_q;
   assign evt_valid    = vld_q;
   assign evt_type     = typ_q;
   assign evt_x        = ex_q;
   assign evt_y        = ey_q;
   assign evt_x0       = ex0_q;
   assign evt_y0       = ey0_q;
   assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_mouse_event_ctrl.sv
// Directed bench for mouse_event_ctrl: clamp vector table plus hand-timed
// press/drag/overflow/reset sequences with DEBOUNCE_CYC=4, DRAG_THRESH=4.
module tb_mouse_event_ctrl;

   logic        pclk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic        left, right, evt_ready, clr_overflow;
   logic [11:0] xpos_clamp, ypos_clamp, evt_x, evt_y, evt_x0, evt_y0;
   logic        dragging, evt_valid, evt_overflow;
   logic [1:0]  evt_type;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic [11:0] ex;
      logic [11:0] ey;
   } clamp_vec_t;

   clamp_vec_t tbl[6];

   mouse_event_ctrl #(.DEBOUNCE_CYC(4), .DRAG_THRESH(4), .XMAX(799), .YMAX(599)) dut (
      .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left), .right(right),
      .xpos_clamp(xpos_clamp), .ypos_clamp(ypos_clamp), .dragging(dragging),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
      .evt_x(evt_x), .evt_y(evt_y), .evt_x0(evt_x0), .evt_y0(evt_y0),
      .evt_overflow(evt_overflow), .clr_overflow(clr_overflow)
   );

   always #5 pclk = ~pclk;

   task automatic step(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      logic seen;
      tbl[0] = '{12'd0,    12'd0,    12'd0,   12'd0};
      tbl[1] = '{12'd799,  12'd599,  12'd799, 12'd599};
      tbl[2] = '{12'd800,  12'd600,  12'd799, 12'd599};
      tbl[3] = '{12'd1500, 12'd4095, 12'd799, 12'd599};
      tbl[4] = '{12'd798,  12'd598,  12'd798, 12'd598};
      tbl[5] = '{12'd4095, 12'd0,    12'd799, 12'd0};

      rst = 1'b0; xpos = 12'd0; ypos = 12'd0; left = 1'b0; right = 1'b0;
      evt_ready = 1'b1; clr_overflow = 1'b0;
      step(2);
      chk("rst_valid", evt_valid, 0);
      chk("rst_drag", dragging, 0);
      chk("rst_ovf", evt_overflow, 0);
      chk("rst_xc", xpos_clamp, 0);
      rst = 1'b1;
      step(1);

      // Clamp table: one-cycle registered min().
      for (int i = 0; i < 6; i++) begin
         xpos = tbl[i].x;
         ypos = tbl[i].y;
         step(1);
         chk("clamp_x", xpos_clamp, tbl[i].ex);
         chk("clamp_y", ypos_clamp, tbl[i].ey);
      end

      // Glitch rejection, then a click at (100,50).
      xpos = 12'd100; ypos = 12'd50;
      step(2);
      left = 1'b1; step(3); left = 1'b0; step(6);
      chk("glitch_valid", evt_valid, 0);
      left = 1'b1; step(10);
      chk("hold_valid", evt_valid, 0);
      left = 1'b0; step(4);
      chk("click_early", evt_valid, 0);
      step(1);
      chk("click_valid", evt_valid, 1);
      chk("click_type", evt_type, 0);
      chk("click_x", evt_x, 100);
      chk("click_y", evt_y, 50);
      chk("click_x0", evt_x0, 100);
      step(1);
      chk("click_drain", evt_valid, 0);

      // Drag beyond threshold.
      xpos = 12'd200; ypos = 12'd200; step(2);
      left = 1'b1; step(5);
      xpos = 12'd205; step(1);
      chk("ds_early_drag", dragging, 0);
      chk("ds_early_valid", evt_valid, 0);
      step(1);
      chk("ds_valid", evt_valid, 1);
      chk("ds_type", evt_type, 2);
      chk("ds_x", evt_x, 200);
      chk("ds_x0", evt_x0, 200);
      chk("ds_drag", dragging, 1);
      step(1);
      chk("ds_drain", evt_valid, 0);
      left = 1'b0; step(4);
      chk("de_early_valid", evt_valid, 0);
      chk("de_still_drag", dragging, 1);
      step(1);
      chk("de_valid", evt_valid, 1);
      chk("de_type", evt_type, 3);
      chk("de_x", evt_x, 205);
      chk("de_x0", evt_x0, 200);
      chk("de_drag", dragging, 0);
      step(1);

      // Displacement exactly at threshold stays a click.
      xpos = 12'd200; ypos = 12'd200; step(2);
      left = 1'b1; step(5);
      xpos = 12'd204; step(6);
      chk("th_drag", dragging, 0);
      chk("th_valid", evt_valid, 0);
      left = 1'b0; step(5);
      chk("th_click_valid", evt_valid, 1);
      chk("th_click_type", evt_type, 0);
      chk("th_click_x", evt_x, 200);
      step(1);

      // Stalled slot: CLICK_R held, CLICK_L dropped, overflow set then cleared.
      xpos = 12'd300; ypos = 12'd100; step(2);
      evt_ready = 1'b0;
      right = 1'b1; step(4);
      chk("cr_early", evt_valid, 0);
      step(1);
      chk("cr_valid", evt_valid, 1);
      chk("cr_type", evt_type, 1);
      chk("cr_x", evt_x, 300);
      chk("cr_y0", evt_y0, 100);
      right = 1'b0; step(5);
      chk("cr_no_ovf", evt_overflow, 0);
      xpos = 12'd310; step(2);
      left = 1'b1; step(5); left = 1'b0; step(5);
      chk("ovf_set", evt_overflow, 1);
      chk("ovf_hold_valid", evt_valid, 1);
      chk("ovf_hold_type", evt_type, 1);
      chk("ovf_hold_x", evt_x, 300);
      clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
      chk("ovf_clr", evt_overflow, 0);
      chk("ovf_clr_valid", evt_valid, 1);
      evt_ready = 1'b1; step(1);
      chk("stall_drain", evt_valid, 0);

      // Left click and right click in the same cycle, clear held high.
      left = 1'b1; step(5);
      clr_overflow = 1'b1; left = 1'b0; right = 1'b1; step(4);
      chk("sim_early", evt_valid, 0);
      chk("sim_ovf_cleared", evt_overflow, 0);
      step(1);
      chk("sim_valid", evt_valid, 1);
      chk("sim_type", evt_type, 0);
      chk("sim_ovf", evt_overflow, 1);
      clr_overflow = 1'b0; right = 1'b0; step(6);
      clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;

      // Asynchronous reset in the middle of a drag.
      xpos = 12'd200; ypos = 12'd200; step(2);
      left = 1'b1; step(5);
      xpos = 12'd210; step(2);
      chk("pre_rst_drag", dragging, 1);
      #2 rst = 1'b0; left = 1'b0;
      #1;
      chk("arst_drag", dragging, 0);
      chk("arst_valid", evt_valid, 0);
      chk("arst_xc", xpos_clamp, 0);
      step(2);
      #3 rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (evt_valid) seen = 1'b1;
      end
      chk("no_evt_after_rst", seen, 0);
      chk("no_drag_after_rst", dragging, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
